// File: rtl/retire_monitor.sv
// Passive retire-interface monitor: pc continuity check, cycle/instret/trap counters,
// a {pc, inst, trap} trace FIFO drained over valid/ready, and a sticky halt latch.
module retire_monitor #(
    parameter logic [31:0] RESET_ADDR  = 32'h0,
    parameter int unsigned TRACE_DEPTH = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_retire_valid,
    input  logic [31:0]      i_retire_inst,
    input  logic             i_retire_trap,
    input  logic             i_retire_halt,
    input  logic [31:0]      i_retire_pc,
    input  logic [31:0]      i_retire_next_pc,
    output logic             o_trace_valid,
    input  logic             i_trace_ready,
    output logic [31:0]      o_trace_pc,
    output logic [31:0]      o_trace_inst,
    output logic             o_trace_trap,
    output logic             o_trace_overflow,
    output logic [CNT_W-1:0] o_cycle_count,
    output logic [CNT_W-1:0] o_instret_count,
    output logic [CNT_W-1:0] o_trap_count,
    output logic             o_err,
    output logic [31:0]      o_err_pc,
    output logic             o_halted
);

    localparam int unsigned PTR_W = $clog2(TRACE_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(TRACE_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    state_t           state;
    logic [31:0]      expected_pc;
    logic [31:0]      mem_pc   [TRACE_DEPTH];
    logic [31:0]      mem_inst [TRACE_DEPTH];
    logic             mem_trap [TRACE_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   count;

    logic accept;
    logic full;
    logic pop;
    logic push;
    logic drop;

    assign accept = i_retire_valid && (state != HALTED);
    assign full   = (count == FULL_CNT);
    assign pop    = (count != '0) && i_trace_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push   = accept && (!full || pop);
    assign drop   = accept && full && !pop;

    assign o_trace_valid = (count != '0);
    assign o_trace_pc    = o_trace_valid ? mem_pc[rd_ptr]   : '0;
    assign o_trace_inst  = o_trace_valid ? mem_inst[rd_ptr] : '0;
    assign o_trace_trap  = o_trace_valid ? mem_trap[rd_ptr] : 1'b0;

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_pc[wr_ptr]   <= i_retire_pc;
            mem_inst[wr_ptr] <= i_retire_inst;
            mem_trap[wr_ptr] <= i_retire_trap;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_ptr           <= '0;
            wr_ptr           <= '0;
            count            <= '0;
            o_trace_overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) o_trace_overflow <= 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= IDLE;
            expected_pc     <= RESET_ADDR;
            o_cycle_count   <= '0;
            o_instret_count <= '0;
            o_trap_count    <= '0;
            o_err           <= 1'b0;
            o_err_pc        <= '0;
            o_halted        <= 1'b0;
        end else begin
            if (state != HALTED) o_cycle_count <= o_cycle_count + 1'b1;
            if (accept) begin
                o_instret_count <= o_instret_count + 1'b1;
                if (i_retire_trap) o_trap_count <= o_trap_count + 1'b1;
                expected_pc <= i_retire_next_pc;
                if ((i_retire_pc != expected_pc) && !o_err) begin
                    o_err    <= 1'b1;
                    o_err_pc <= i_retire_pc;
                end
                if (i_retire_halt) begin
                    state    <= HALTED;
                    o_halted <= 1'b1;
                end else begin
                    state <= RUN;
                end
            end
        end
    end

endmodule

// File: tb/tb_retire_monitor.sv
// Directed bench for retire_monitor: continuity errors, trace FIFO ordering/overflow,
// trap/halt counting and asynchronous reset.
module tb_retire_monitor;

    logic        clk;
    logic        rst_n;
    logic        retire_valid;
    logic [31:0] retire_inst;
    logic        retire_trap;
    logic        retire_halt;
    logic [31:0] retire_pc;
    logic [31:0] retire_next_pc;
    logic        trace_valid;
    logic        trace_ready;
    logic [31:0] trace_pc;
    logic [31:0] trace_inst;
    logic        trace_trap;
    logic        trace_overflow;
    logic [31:0] cycle_count;
    logic [31:0] instret_count;
    logic [31:0] trap_count;
    logic        err;
    logic [31:0] err_pc;
    logic        halted;

    int compared   = 0;
    int mismatched = 0;

    retire_monitor #(.RESET_ADDR(32'h0), .TRACE_DEPTH(16), .CNT_W(32)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_retire_valid   (retire_valid),
        .i_retire_inst    (retire_inst),
        .i_retire_trap    (retire_trap),
        .i_retire_halt    (retire_halt),
        .i_retire_pc      (retire_pc),
        .i_retire_next_pc (retire_next_pc),
        .o_trace_valid    (trace_valid),
        .i_trace_ready    (trace_ready),
        .o_trace_pc       (trace_pc),
        .o_trace_inst     (trace_inst),
        .o_trace_trap     (trace_trap),
        .o_trace_overflow (trace_overflow),
        .o_cycle_count    (cycle_count),
        .o_instret_count  (instret_count),
        .o_trap_count     (trap_count),
        .o_err            (err),
        .o_err_pc         (err_pc),
        .o_halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Present one retirement across a single rising edge; returns 1 time unit after it.
    task automatic retire(input logic [31:0] pc, input logic [31:0] npc, input logic trap, input logic halt);
        retire_valid   = 1'b1;
        retire_pc      = pc;
        retire_next_pc = npc;
        retire_inst    = 32'h0000_0013;
        retire_trap    = trap;
        retire_halt    = halt;
        @(posedge clk);
        #1;
        retire_valid = 1'b0;
        retire_trap  = 1'b0;
        retire_halt  = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n          = 1'b0;
        retire_valid   = 1'b0;
        retire_inst    = '0;
        retire_trap    = 1'b0;
        retire_halt    = 1'b0;
        retire_pc      = '0;
        retire_next_pc = '0;
        trace_ready    = 1'b0;
        #12;
        chk("rst_trace_valid", trace_valid, 0);
        chk("rst_trace_pc", trace_pc, 0);
        chk("rst_trace_inst", trace_inst, 0);
        chk("rst_overflow", trace_overflow, 0);
        chk("rst_cycle", cycle_count, 0);
        chk("rst_instret", instret_count, 0);
        chk("rst_err", err, 0);
        chk("rst_halted", halted, 0);
        rst_n       = 1'b1;
        trace_ready = 1'b1;

        // Sequential run, trace head follows each retire by one edge
        retire(32'h0, 32'h4, 1'b0, 1'b0);
        chk("seq_head0_valid", trace_valid, 1);
        chk("seq_head0_pc", trace_pc, 32'h0);
        retire(32'h4, 32'h8, 1'b0, 1'b0);
        chk("seq_head1_pc", trace_pc, 32'h4);
        chk("seq_head1_inst", trace_inst, 32'h0000_0013);
        retire(32'h8, 32'hc, 1'b0, 1'b0);
        chk("seq_head2_pc", trace_pc, 32'h8);
        chk("seq_instret", instret_count, 3);
        chk("seq_err", err, 0);
        chk("seq_cycle", cycle_count, 3);
        idle_cycle();
        chk("seq_drained", trace_valid, 0);
        chk("seq_cycle_idle", cycle_count, 4);

        // Discontinuity: first offender latched, later ones ignored
        pulse_reset();
        retire(32'h0, 32'h4, 1'b0, 1'b0);
        retire(32'h10, 32'h14, 1'b0, 1'b0);
        chk("disc_err", err, 1);
        chk("disc_err_pc", err_pc, 32'h10);
        retire(32'h20, 32'h24, 1'b0, 1'b0);
        chk("disc_err_pc_sticky", err_pc, 32'h10);

        // First retire must be at RESET_ADDR
        pulse_reset();
        chk("first_err_clear", err, 0);
        retire(32'h4, 32'h8, 1'b0, 1'b0);
        chk("first_err", err, 1);
        chk("first_err_pc", err_pc, 32'h4);

        // Fill, push+pop while full, then drop on full
        pulse_reset();
        trace_ready = 1'b0;
        for (int i = 0; i < 16; i++)
            retire(32'(4 * i), 32'(4 * i + 4), 1'b0, 1'b0);
        chk("fill_overflow", trace_overflow, 0);
        chk("fill_head", trace_pc, 32'h0);
        trace_ready = 1'b1;
        retire(32'd64, 32'd68, 1'b0, 1'b0);
        chk("full_pushpop_overflow", trace_overflow, 0);
        chk("full_pushpop_head", trace_pc, 32'd4);
        trace_ready = 1'b0;
        retire(32'd68, 32'd72, 1'b0, 1'b0);
        chk("full_drop_overflow", trace_overflow, 1);
        chk("full_drop_instret", instret_count, 18);
        trace_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain_valid", trace_valid, 1);
            chk("drain_pc", trace_pc, 64'(4 * (i + 1)));
            idle_cycle();
        end
        chk("drain_empty", trace_valid, 0);
        chk("drain_empty_pc", trace_pc, 0);

        // Trap then halt, later retirements ignored
        pulse_reset();
        retire(32'h0, 32'h4, 1'b1, 1'b0);
        chk("trap_head_flag", trace_trap, 1);
        retire(32'h4, 32'h8, 1'b0, 1'b1);
        chk("halt_halted", halted, 1);
        chk("halt_head_pc", trace_pc, 32'h4);
        retire(32'h8, 32'hc, 1'b1, 1'b0);
        retire(32'hc, 32'h10, 1'b1, 1'b0);
        chk("halt_trap_count", trap_count, 1);
        chk("halt_instret", instret_count, 2);
        chk("halt_cycle_frozen", cycle_count, 2);
        chk("halt_no_push", trace_valid, 0);
        chk("halt_still", halted, 1);

        // Asynchronous reset between edges
        pulse_reset();
        retire(32'h0, 32'h4, 1'b0, 1'b0);
        retire(32'h4, 32'h8, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("async_instret", instret_count, 0);
        chk("async_cycle", cycle_count, 0);
        chk("async_trace_valid", trace_valid, 0);
        chk("async_trace_pc", trace_pc, 0);
        rst_n = 1'b1;
        #1;
        retire(32'h8, 32'hc, 1'b0, 1'b0);
        chk("async_expected_pc_err", err, 1);
        chk("async_expected_pc_err_pc", err_pc, 32'h8);
        chk("async_instret_after", instret_count, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/retire_monitor.md
Name: retire_monitor

Overview:
- Passive consumer of the hart's instruction-retire interface; sits directly downstream of the hart in simulation and FPGA debug builds.
- Checks control-flow continuity (each retired pc must equal the previous next_pc) and maintains cycle, retired-instruction and trap counters.
- Buffers {pc, inst, trap} records in a trace FIFO drained over a valid/ready port, and latches halt.

Parameters:
- RESET_ADDR, 32'h0, pc required for the first retired instruction after reset.
- TRACE_DEPTH, 16, trace FIFO entries; power of two, ≥2.
- CNT_W, 32, width of all counters.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_retire_valid  in  1  an instruction retires this cycle.
- i_retire_inst  in  32  retired instruction word.
- i_retire_trap  in  1  retired instruction trapped.
- i_retire_halt  in  1  retired instruction halts the hart.
- i_retire_pc  in  32  pc of the retired instruction.
- i_retire_next_pc  in  32  pc of the following instruction.
- o_trace_valid  out  1  FIFO head is valid.
- i_trace_ready  in  1  consumer accepts the head this cycle.
- o_trace_pc  out  32  pc at the FIFO head.
- o_trace_inst  out  32  instruction word at the FIFO head.
- o_trace_trap  out  1  trap flag at the FIFO head.
- o_trace_overflow  out  1  sticky; at least one record was dropped.
- o_cycle_count  out  CNT_W  cycles spent in RUN or IDLE since reset.
- o_instret_count  out  CNT_W  accepted retirements.
- o_trap_count  out  CNT_W  accepted retirements with trap=1.
- o_err  out  1  sticky pc-discontinuity error.
- o_err_pc  out  32  pc of the first offending retirement.
- o_halted  out  1  halt observed.

Behaviour:
- Reset (i_rst_n=0, asynchronous): all counters 0, FIFO empty, o_trace_valid=0, o_trace_pc/inst/trap=0, o_trace_overflow=0, o_err=0, o_err_pc=0, o_halted=0, state=IDLE, expected_pc=RESET_ADDR.
- A reset asserted mid-operation clears everything immediately, including FIFO contents.
- States:
  - IDLE: no retirement seen yet. Goes to RUN on an accepted retire with halt=0, or to HALTED on an accepted retire with halt=1.
  - RUN: goes to HALTED on an accepted retire with halt=1.
  - HALTED: terminal until reset.
- Accepted retire: i_retire_valid=1 while in IDLE or RUN. Retirements in HALTED are ignored entirely: no counting, no check, no push.
- Cycle counter: increments every clock in IDLE and RUN, including the clock whose edge enters HALTED. Frozen in HALTED.
- On an accepted retire:
  - o_instret_count increments by 1.
  - o_trap_count increments by 1 if trap=1.
  - expected_pc is set to i_retire_next_pc.
- Continuity check: on an accepted retire, if i_retire_pc != expected_pc and o_err=0, set o_err=1 and o_err_pc=i_retire_pc. Later mismatches do not update o_err_pc.
- Halt: o_halted=1 from the edge that accepts a halt retire. That instruction is counted, checked and traced like any other.
- Counters wrap modulo 2^CNT_W with no saturation.
- Trace FIFO (circular buffer with read/write pointers and an occupancy count 0..TRACE_DEPTH):
  - Push a record on every accepted retire.
  - Pop when o_trace_valid & i_trace_ready.
  - o_trace_valid = (count != 0). Head fields are driven from storage at the read pointer and are 0 when empty.
  - A record pushed at edge k is visible at the head after edge k if the FIFO was empty (one-cycle latency).
  - Full with push and no pop: record dropped, o_trace_overflow set, occupancy unchanged.
  - Full with simultaneous push and pop: both occur, no drop, count stays TRACE_DEPTH.
  - Empty with pop requested: no effect (o_trace_valid is 0 anyway).
  - Pointers wrap at TRACE_DEPTH.
  - The FIFO keeps draining in HALTED.
- All outputs are registers or decode of registers only; there is no combinational path from i_retire_* to any output.

Test Plan:
- Reset, then retire pc=0→4, 4→8, 8→12 (inst 00000013) with ready=1 → o_instret_count=3, o_err=0, and trace delivers pcs 0, 4, 8 in order, each one cycle after its retire.
- Retire pc=0→4, then pc=0x10 → o_err=1, o_err_pc=0x10. A further retire at pc=0x20 leaves o_err_pc=0x10.
- First retire at pc=4 with RESET_ADDR=0 → o_err=1, o_err_pc=4.
- Hold ready=0 and retire 17 sequential instructions with DEPTH=16 → count=16, o_trace_overflow=1. Draining yields the first 16 pcs. On a full FIFO, push with ready=1 in the same cycle → no overflow.
- Retire with trap=1, then one with halt=1; assert further valid retires → o_trap_count=1, o_instret_count=2, o_halted=1. Counters and the cycle count stay frozen afterwards.
- Drop i_rst_n mid-run between clock edges → all outputs 0 immediately. After release, the first retire must be at RESET_ADDR.
